// File: rtl/micro_tiles_pkg.sv
// micro_tiles_pkg: shared state enum, default sizes and one-hot helper for the tile switch controller
package micro_tiles_pkg;
  localparam int NUM_TILES_DEF = 4;
  localparam int SEL_W_DEF = 2;
  typedef enum logic [1:0] {RUN, DRAIN, RST_NEW} state_t;
  function automatic logic [31:0] onehot(input logic [31:0] i);
    return 32'd1 << i;
  endfunction
endpackage

// File: rtl/micro_tile_switch_ctrl_if.sv
// micro_tile_switch_ctrl_if: pin bus (ui_in, tile_uo_in from pins/tiles; tile_ui_out, uo_out to tiles/pins); master drives pins, slave is the controller
interface micro_tile_switch_ctrl_if #(parameter int NUM_TILES = 4);
  logic [7:0] ui_in;
  logic [7:0] tile_ui_out;
  logic [7:0] uo_out;
  logic [8*NUM_TILES-1:0] tile_uo_in;
  modport master(output ui_in, tile_uo_in, input tile_ui_out, uo_out);
  modport slave(input ui_in, tile_uo_in, output tile_ui_out, uo_out);
endinterface

// File: rtl/micro_sel_stabilizer.sv
// micro_sel_stabilizer: debounces sel_in (clk, rst, sel_in in; cand, cand_valid out once cand held STABLE_CYCLES samples)
module micro_sel_stabilizer #(
  parameter int SEL_W = 2,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] sel_in,
  output logic [SEL_W-1:0] cand,
  output logic             cand_valid
);
  logic [CNT_W-1:0] stab_cnt;
  assign cand_valid = stab_cnt == CNT_W'(STABLE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (rst) begin
      cand <= '0;
      stab_cnt <= '0;
    end else if (sel_in != cand) begin
      cand <= sel_in;
      stab_cnt <= '0;
    end else if (!cand_valid) begin
      stab_cnt <= stab_cnt + 1'b1;
    end
  end
endmodule

// File: rtl/micro_tile_switch_ctrl.sv
// micro_tile_switch_ctrl: sequences tile hand-over (clk, rst, sel_in, tile_rst_req, bus in; tile_clk_en, tile_rst_n, active_sel, out_valid, busy out)
module micro_tile_switch_ctrl
  import micro_tiles_pkg::*;
#(
  parameter int NUM_TILES = NUM_TILES_DEF,
  parameter int SEL_W = SEL_W_DEF,
  parameter int STABLE_CYCLES = 4,
  parameter int DRAIN_CYCLES = 2,
  parameter int RST_CYCLES = 8,
  parameter int CNT_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [SEL_W-1:0]     sel_in,
  input  logic                 tile_rst_req,
  micro_tile_switch_ctrl_if.slave bus,
  output logic [NUM_TILES-1:0] tile_clk_en,
  output logic [NUM_TILES-1:0] tile_rst_n,
  output logic [SEL_W-1:0]     active_sel,
  output logic                 out_valid,
  output logic                 busy
);
  state_t state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [SEL_W-1:0] target, target_d, sel_d, cand;
  logic [NUM_TILES-1:0] clk_en_d, rst_n_d;
  logic cand_valid, last, go;
  micro_sel_stabilizer #(.SEL_W(SEL_W), .STABLE_CYCLES(STABLE_CYCLES), .CNT_W(CNT_W)) u_stab (
    .clk(clk),
    .rst(rst),
    .sel_in(sel_in),
    .cand(cand),
    .cand_valid(cand_valid)
  );
  always_comb begin
    last = cnt == CNT_W'(state == DRAIN ? DRAIN_CYCLES - 1 : RST_CYCLES - 1);
    go = cand_valid && cand != active_sel;
    state_d = state == RUN ? (go ? DRAIN : RUN) : !last ? state : state == DRAIN ? RST_NEW : RUN;
    cnt_d = (state == RUN || last) ? '0 : cnt + 1'b1;
    target_d = (state == RUN && go) ? cand : target;
    sel_d = (state == DRAIN && last) ? target : active_sel;
    clk_en_d = state_d == DRAIN ? '0 : NUM_TILES'(onehot(32'(sel_d)));
    rst_n_d = (state_d == RUN && !tile_rst_req) ? NUM_TILES'(onehot(32'(sel_d))) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RST_NEW;
      cnt <= '0;
      active_sel <= '0;
      target <= '0;
      tile_clk_en <= NUM_TILES'(1);
      tile_rst_n <= '0;
      out_valid <= 1'b0;
      busy <= 1'b1;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      active_sel <= sel_d;
      target <= target_d;
      tile_clk_en <= clk_en_d;
      tile_rst_n <= rst_n_d;
      out_valid <= state_d == RUN;
      busy <= state_d != RUN;
    end
  end
  assign bus.uo_out = out_valid ? bus.tile_uo_in[8*active_sel +: 8] : '0;
  assign bus.tile_ui_out = out_valid ? bus.ui_in : '0;
endmodule
